mem_xfer_sequencer: RTL and testbench
=====================================

Name: mem_xfer_sequencer

Overview:
- Clocked sequencer for the memory-to-memory transfer datapath: memory A, memory B, address counters A/B and the transfer register.
- On a start request it clears the transfer register, fills memory A with `len` words, rewinds address A, then copies `len` words A->B through the register, and signals done.
- Replaces the decode-only controller's external state source: it owns the state register and the address counters, and drives the same control strobes (wea, inc_a, inc_b, web, rstor).

Parameters:
ADDR_W, 3, address width of memories A and B; depth = 2**ADDR_W
LEN_W, ADDR_W+1, width of transfer-length input (allows len = 2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
len  in  LEN_W  word count, captured with start; legal 0..2**ADDR_W
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of transfer
wea  out  1  write enable, memory A
web  out  1  write enable, memory B
inc_a  out  1  increment address counter A
inc_b  out  1  increment address counter B
rstor  out  1  synchronous clear of transfer register
addr_a  out  ADDR_W  address counter A
addr_b  out  ADDR_W  address counter B

Behaviour:
- Reset (rst_n low, async): state IDLE, addr_a=0, addr_b=0, len_q=0, word count=0. busy, done, wea, web, inc_a and inc_b are 0. rstor=1 while rst_n is low (combinational OR with reset), 0 after release.
- All strobes are Moore outputs decoded from the state register. Counters update on the clock edge where their inc is high.
- IDLE: start=1 -> capture len into len_q, clear word count -> CLR. start while not IDLE is ignored.
- CLR (1 cycle): rstor=1; addr_a and addr_b forced to 0. If len_q==0 -> DONE, else -> FILL.
- FILL: wea=1, inc_a=1 each cycle; word count +1. When count==len_q-1 on this edge -> REWIND. Exactly len_q write cycles.
- REWIND (1 cycle): addr_a forced to 0, word count cleared -> RD.
- RD (1 cycle): all strobes 0; memory A read data at addr_a is loaded into the transfer register by the datapath -> WR.
- WR (1 cycle): web=1, inc_a=1, inc_b=1; word count +1. If count==len_q-1 -> DONE, else -> RD. Each word takes 2 cycles.
- DONE (1 cycle): done=1, busy=1 -> IDLE. busy drops in the cycle after done.
- Total latency from the start edge to the done cycle: 2 + len_q + 1 + 2*len_q cycles; for len=0 it is 2 cycles (CLR, DONE).
- Address counters wrap modulo 2**ADDR_W. With len=2**ADDR_W, both counters end at 0.
- len > 2**ADDR_W: clamped to 2**ADDR_W at capture.
- Reset asserted mid-operation: immediate return to IDLE with all counters 0; no done pulse.

Optional Feature:
- Macro MEM_XFER_ABORT_EN.
- Defined: adds input `abort` (1 bit). abort=1 in FILL, RD or WR forces the next state to DONE with done=1; addresses hold their current values. abort in IDLE, CLR, REWIND or DONE is ignored.
- Not defined: no abort port; the sequence always runs to completion.

Decomposition:
- Shared package mem_xfer_pkg: state enum (IDLE, CLR, FILL, REWIND, RD, WR, DONE, 3-bit encoding) and default ADDR_W.
- One sub-module, xfer_addr_counter: ADDR_W-bit counter with async active-low reset, sync clear and inc. Instantiated twice, for addr_a and addr_b.

Test Plan:
- Reset: rst_n=0 for 3 cycles mid-FILL (len=5) -> IDLE, addr_a=addr_b=0, rstor=1 during reset, all other outputs 0.
- len=4, start pulse -> CLR 1 cycle (rstor=1); wea high 4 cycles over addr_a 0..3; REWIND; 4 RD/WR pairs with web at addr_b 0..3; done high 1 cycle, 15 cycles after the start edge.
- len=0 -> CLR then DONE: done high 2 cycles after the start edge; wea and web never asserted.
- len=8 with ADDR_W=3 -> addr_a wraps 7->0 at the end of FILL, addr_b wraps 7->0 after the last WR; 8 web pulses.
- start re-pulsed during FILL and WR -> ignored; len_q is unchanged and exactly one done pulse is seen.
- With MEM_XFER_ABORT_EN, len=6, abort during the 3rd WR -> done on the next cycle, addr_b=3, busy low afterwards; without the macro, a compile check that the abort port is absent.

Source files
------------

// File: rtl/mem_xfer_pkg.sv
// rtl/mem_xfer_pkg.sv - shared state encoding and defaults for the memory transfer sequencer
package mem_xfer_pkg;

  localparam int ADDR_W_DEF = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    FILL   = 3'd2,
    REWIND = 3'd3,
    RD     = 3'd4,
    WR     = 3'd5,
    DONE   = 3'd6
  } xfer_state_t;

endpackage

// File: rtl/xfer_addr_counter.sv
// rtl/xfer_addr_counter.sv - wrapping address counter with sync clear and increment
module xfer_addr_counter #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  // clear wins over inc; wraps modulo 2**ADDR_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/mem_xfer_sequencer.sv
// rtl/mem_xfer_sequencer.sv - fill memory A then copy A->B through the transfer register
// Optional abort input enabled by MEM_XFER_ABORT_EN.
module mem_xfer_sequencer
  import mem_xfer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef MEM_XFER_ABORT_EN
  input  logic              abort,
`endif
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              wea,
  output logic              web,
  output logic              inc_a,
  output logic              inc_b,
  output logic              rstor,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(2 ** ADDR_W);

  xfer_state_t      state, state_nxt;
  logic [LEN_W-1:0] len_q, cnt, len_cl;
  logic             last_word, clr_a, clr_b, rstor_s, abort_hit;

  assign len_cl    = (len > DEPTH_L) ? DEPTH_L : len;
  assign last_word = (cnt == len_q - LEN_W'(1));

`ifdef MEM_XFER_ABORT_EN
  assign abort_hit = abort && (state == FILL || state == RD || state == WR);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len_cl;
            cnt   <= '0;
          end
        end
        FILL, WR: cnt <= cnt + LEN_W'(1);
        REWIND:   cnt <= '0;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    wea       = 1'b0;
    web       = 1'b0;
    inc_a     = 1'b0;
    inc_b     = 1'b0;
    clr_a     = 1'b0;
    clr_b     = 1'b0;
    rstor_s   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CLR;
      CLR: begin
        rstor_s   = 1'b1;
        clr_a     = 1'b1;
        clr_b     = 1'b1;
        state_nxt = (len_q == '0) ? DONE : FILL;
      end
      FILL: begin
        wea       = 1'b1;
        inc_a     = 1'b1;
        state_nxt = last_word ? REWIND : FILL;
      end
      REWIND: begin
        clr_a     = 1'b1;
        state_nxt = RD;
      end
      RD: state_nxt = WR;
      WR: begin
        web       = 1'b1;
        inc_a     = 1'b1;
        inc_b     = 1'b1;
        state_nxt = last_word ? DONE : RD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // the strobes of the aborted cycle still take effect; only the successor changes
    if (abort_hit) state_nxt = DONE;
  end

  assign busy  = (state != IDLE);
  assign rstor = rstor_s | ~rst_n;

  xfer_addr_counter #(.ADDR_W(ADDR_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_a),
    .inc   (inc_a),
    .addr  (addr_a)
  );

  xfer_addr_counter #(.ADDR_W(ADDR_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_b),
    .inc   (inc_b),
    .addr  (addr_b)
  );

endmodule

// File: tb/tb_mem_xfer_sequencer.sv
// tb/tb_mem_xfer_sequencer.sv - directed self-checking bench for mem_xfer_sequencer
module tb_mem_xfer_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       busy, done, wea, web, inc_a, inc_b, rstor;
  logic [2:0] addr_a, addr_b;
`ifdef MEM_XFER_ABORT_EN
  logic       abort;
`endif

  int checks;
  int errors;

  mem_xfer_sequencer #(.ADDR_W(3), .LEN_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
`ifdef MEM_XFER_ABORT_EN
    .abort  (abort),
`endif
    .len    (len),
    .busy   (busy),
    .done   (done),
    .wea    (wea),
    .web    (web),
    .inc_a  (inc_a),
    .inc_b  (inc_b),
    .rstor  (rstor),
    .addr_a (addr_a),
    .addr_b (addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".strobes"}, 32'({wea, web, inc_a, inc_b}), 0);
    chk({tag, ".addr_a"}, 32'(addr_a), 0);
    chk({tag, ".addr_b"}, 32'(addr_b), 0);
  endtask

  // Runs one transfer; restart re-pulses start (len=2) in a FILL and a WR cycle of a len=4 run.
  task automatic run_xfer(input string tag, input int l, input int exp_words, input int exp_lat,
                          input int exp_fa, input int exp_fb, input bit restart);
    int wa_n, wb_n, done_n, done_at, cyc;
    wa_n = 0; wb_n = 0; done_n = 0; done_at = 0;
    @(negedge clk);
    start = 1'b1;
    len   = 4'(l);
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".clr_rstor"}, 32'(rstor), 1);
    chk({tag, ".clr_busy"}, 32'(busy), 1);
    for (cyc = 1; cyc <= 60; cyc++) begin
      if (wea) begin
        chk({tag, ".wea_addr"}, 32'(addr_a), 32'(wa_n % 8));
        wa_n++;
      end
      if (web) begin
        chk({tag, ".web_addr"}, 32'(addr_b), 32'(wb_n % 8));
        wb_n++;
      end
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = cyc;
      end
      if (!busy) break;
      start = restart && (cyc == 3 || cyc == 8);
      if (start) len = 4'd2;
      @(negedge clk);
      start = 1'b0;
    end
    chk({tag, ".done_cycle"}, 32'(done_at), 32'(exp_lat));
    chk({tag, ".done_count"}, 32'(done_n), 1);
    chk({tag, ".wea_count"}, 32'(wa_n), 32'(exp_words));
    chk({tag, ".web_count"}, 32'(wb_n), 32'(exp_words));
    chk({tag, ".busy_after"}, 32'(busy), 0);
    chk({tag, ".final_addr_a"}, 32'(addr_a), 32'(exp_fa));
    chk({tag, ".final_addr_b"}, 32'(addr_b), 32'(exp_fb));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    len    = 4'd0;
`ifdef MEM_XFER_ABORT_EN
    abort  = 1'b0;
`endif

    // power-on reset
    @(negedge clk);
    chk("por.rstor", 32'(rstor), 1);
    chk_idle_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("por_rel.rstor", 32'(rstor), 0);
    chk_idle_outputs("por_rel");

    // len=4 basic transfer: done in cycle 15 counted from the start edge
    run_xfer("len4", 4, 4, 15, 4, 4, 1'b0);

    // len=0: CLR then DONE, no writes
    run_xfer("len0", 0, 0, 2, 0, 0, 1'b0);

    // len=8: both counters wrap back to 0
    run_xfer("len8", 8, 8, 27, 0, 0, 1'b0);

    // len=12 clamps to 8
    run_xfer("len12", 12, 8, 27, 0, 0, 1'b0);

    // start re-pulsed in FILL and WR is ignored
    run_xfer("restart", 4, 4, 15, 4, 4, 1'b1);

    // reset mid-FILL with len=5
    @(negedge clk);
    start = 1'b1;
    len   = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midfill.wea", 32'(wea), 1);
    chk("midfill.addr_a", 32'(addr_a), 1);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst.rstor", 32'(rstor), 1);
      chk_idle_outputs("rst");
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst.rstor", 32'(rstor), 0);
      chk_idle_outputs("post_rst");
    end

`ifdef MEM_XFER_ABORT_EN
    // len=6, abort during the 3rd WR (sample cycle 14)
    @(negedge clk);
    start = 1'b1;
    len   = 4'd6;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 14; c++) @(negedge clk);
    chk("abort.in_wr", 32'(web), 1);
    chk("abort.addr_b_pre", 32'(addr_b), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.done", 32'(done), 1);
    chk("abort.addr_b", 32'(addr_b), 3);
    @(negedge clk);
    chk("abort.busy_after", 32'(busy), 0);
    chk("abort.done_after", 32'(done), 0);
    chk("abort.addr_b_hold", 32'(addr_b), 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
